// File: rtl/vsync_gen_pkg.sv
// Shared types and constants for the frame-sync generator.
// The optional PHASE output is enabled by defining VSYNC_GEN_PHASE_EN.
package vsync_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam int FRAME_CNT_W = 16;

endpackage : vsync_gen_pkg

// File: rtl/vsync_gen_if.sv
// Control/status bundle between the frame-sync generator and its host.
// PHASE exists only when VSYNC_GEN_PHASE_EN is defined.
interface vsync_gen_if;
   import vsync_gen_pkg::*;

   logic                   EN;
   logic                   TRIG;
   logic                   V_SYNC;
   logic                   BUSY;
   logic                   FRAME_DONE;
   logic [FRAME_CNT_W-1:0] FRAME_CNT;
`ifdef VSYNC_GEN_PHASE_EN
   logic                   PHASE;
`endif

`ifdef VSYNC_GEN_PHASE_EN
   modport master (input EN, TRIG, output V_SYNC, BUSY, FRAME_DONE, FRAME_CNT, PHASE);
   modport slave  (output EN, TRIG, input V_SYNC, BUSY, FRAME_DONE, FRAME_CNT, PHASE);
`else
   modport master (input EN, TRIG, output V_SYNC, BUSY, FRAME_DONE, FRAME_CNT);
   modport slave  (output EN, TRIG, input V_SYNC, BUSY, FRAME_DONE, FRAME_CNT);
`endif

endinterface : vsync_gen_if

// File: rtl/vsync_gen_frame_timer.sv
// Position counter within a frame; zero on the first V_SYNC-high cycle.
// Flags the last pulse cycle and the last frame cycle.
module frame_timer #(
   parameter int unsigned CNT_W   = 24,
   parameter int unsigned PERIOD  = 800000,
   parameter int unsigned PULSE_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_tick_en,
   output logic o_pulse_end,
   output logic o_frame_end
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_tick_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_pulse_end = (r_cnt == CNT_W'(PULSE_W - 1));
   assign o_frame_end = (r_cnt == CNT_W'(PERIOD - 1));

endmodule : frame_timer

// File: rtl/vsync_gen.sv
// Frame-sync generator: PERIOD-cycle frames opening with a PULSE_W-cycle V_SYNC.
// Define VSYNC_GEN_PHASE_EN to add the PHASE (laser owner) output.
module vsync_gen
   import vsync_gen_pkg::*;
#(
   parameter int unsigned PERIOD  = 800000,
   parameter int unsigned PULSE_W = 16,
   parameter int unsigned CNT_W   = 24
) (
   input  logic        CLK,
   input  logic        RST,
   vsync_gen_if.master bus
);

   if ((PULSE_W < 1) || (PULSE_W >= PERIOD) || (64'(PERIOD) > (64'd1 << CNT_W))) begin : g_param_check
      $error("vsync_gen: require 1 <= PULSE_W < PERIOD <= 2**CNT_W");
   end

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   w_frame_done;
   logic                   w_pulse_end;
   logic                   w_frame_end;
   logic                   r_v_sync;
   logic                   r_busy;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   frame_timer #(
      .CNT_W   (CNT_W),
      .PERIOD  (PERIOD),
      .PULSE_W (PULSE_W)
   ) u_frame_timer (
      .clk         (CLK),
      .rst         (RST),
      .i_clear     ((r_state == IDLE) || w_frame_done),
      .i_tick_en   (r_state != IDLE),
      .o_pulse_end (w_pulse_end),
      .o_frame_end (w_frame_end)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // EN is only consulted in IDLE and on the last frame cycle, so mid-frame changes are inert.
   always_comb begin
      w_state_next = r_state;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.EN || bus.TRIG) begin
               w_state_next = PULSE;
            end
         end
         PULSE: begin
            if (w_pulse_end) begin
               w_state_next = BLANK;
            end
         end
         BLANK: begin
            if (w_frame_end) begin
               w_frame_done = 1'b1;
               w_state_next = bus.EN ? PULSE : IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_v_sync    <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_v_sync <= (w_state_next == PULSE);
         r_busy   <= (w_state_next != IDLE);
         if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
         end
      end
   end

`ifdef VSYNC_GEN_PHASE_EN
   logic r_phase;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_phase <= 1'b0;
      end else if (w_frame_done) begin
         r_phase <= ~r_phase;
      end
   end

   assign bus.PHASE = r_phase;
`endif

   assign bus.V_SYNC     = r_v_sync;
   assign bus.BUSY       = r_busy;
   assign bus.FRAME_DONE = w_frame_done;
   assign bus.FRAME_CNT  = r_frame_cnt;

endmodule : vsync_gen
